// File: rtl/bf_sequencer_pkg.sv
// Shared types and constants for the bf_sequencer slice: sequencer states
// and the Brainfuck byte encodings exchanged with the interpreter.
package bf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        TERM,
        START,
        WAITLOW,
        RUN,
        DONE,
        ABORT
    } state_t;

    localparam logic [7:0] BF_EOF   = 8'h00;
    localparam logic [7:0] BF_INC   = 8'h2B;
    localparam logic [7:0] BF_DEC   = 8'h2D;
    localparam logic [7:0] BF_LEFT  = 8'h3C;
    localparam logic [7:0] BF_RIGHT = 8'h3E;
    localparam logic [7:0] BF_LOOP  = 8'h5B;
    localparam logic [7:0] BF_END   = 8'h5D;
    localparam logic [7:0] BF_OUT   = 8'h2E;
    localparam logic [7:0] BF_IN    = 8'h2C;

    localparam int unsigned WDOG_W = 21;

endpackage

// File: rtl/bf_byte_counter.sv
// Saturating up-counter with synchronous clear, used for the program length
// and delivered-output byte counts.
module bf_byte_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/bf_sequencer.sv
// Host-side sequencer for a Brainfuck interpreter: loads a program, starts
// it, and bridges runtime I/O. Optional RUN watchdog: define BF_SEQ_WDOG_EN.
module bf_sequencer
    import bf_pkg::*;
#(
    parameter int unsigned WDOG_CYCLES = 1048576,
    parameter int unsigned MAX_PROG    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ack,
    input  logic        cmd_last,
    input  logic [7:0]  cmd_data,
    input  logic        rin_valid,
    output logic        rin_ack,
    input  logic [7:0]  rin_data,
    output logic        rout_valid,
    input  logic        rout_ack,
    output logic [7:0]  rout_data,
    output logic        i_in_valid,
    input  logic        i_in_ack,
    output logic [7:0]  i_in_data,
    input  logic        i_out_valid,
    output logic        i_out_ack,
    input  logic [7:0]  i_out_data,
    output logic        i_start,
    input  logic        i_ready,
    output logic        i_rst,
    output logic        busy,
    output logic        done,
    output logic        err_long,
    output logic        timeout,
    output logic [7:0]  prog_len,
    output logic [15:0] out_count
);

    state_t     state, state_nx;
    logic [1:0] wait_cnt;
    logic       abort_cnt;
    logic       clr_all;
    logic       prog_inc;
    logic       out_inc;
    logic       prog_full;
    logic       wdog_hit;

    assign prog_full = (32'(prog_len) >= MAX_PROG);

`ifdef BF_SEQ_WDOG_EN
    logic [WDOG_W-1:0] wdog_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt <= '0;
        end else begin
            wdog_cnt <= (state == RUN) ? wdog_cnt + WDOG_W'(1) : '0;
        end
    end

    assign wdog_hit = (state == RUN) && (32'(wdog_cnt) == WDOG_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (rst || clr_all) begin
            timeout <= 1'b0;
        end else if (state == RUN && state_nx == ABORT) begin
            timeout <= 1'b1;
        end
    end
`else
    // Watchdog compiled out; the limit parameter stays for interface compatibility.
    assign wdog_hit = 1'b0 && (WDOG_CYCLES != 0);
    assign timeout  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            err_long  <= 1'b0;
            wait_cnt  <= '0;
            abort_cnt <= 1'b0;
        end else begin
            state     <= state_nx;
            wait_cnt  <= (state == WAITLOW) ? wait_cnt + 2'd1 : '0;
            abort_cnt <= (state == ABORT);
            if (clr_all) begin
                err_long <= 1'b0;
            end else if (state == LOAD && state_nx == ABORT) begin
                err_long <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        cmd_ack    = 1'b0;
        rin_ack    = 1'b0;
        rout_valid = 1'b0;
        rout_data  = '0;
        i_in_valid = 1'b0;
        i_in_data  = '0;
        i_out_ack  = 1'b0;
        i_start    = 1'b0;
        clr_all    = 1'b0;
        prog_inc   = 1'b0;
        out_inc    = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (cmd_valid && i_ready) begin
                    clr_all  = 1'b1;
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                // An overflowing byte is consumed from the host but never forwarded.
                if (cmd_valid && prog_full) begin
                    cmd_ack  = 1'b1;
                    state_nx = ABORT;
                end else begin
                    i_in_valid = cmd_valid;
                    i_in_data  = cmd_data;
                    cmd_ack    = i_in_ack;
                    if (cmd_valid && i_in_ack) begin
                        prog_inc = 1'b1;
                        if (cmd_last) begin
                            state_nx = TERM;
                        end
                    end
                end
            end
            TERM: begin
                i_in_valid = 1'b1;
                i_in_data  = BF_EOF;
                if (i_in_ack) begin
                    state_nx = START;
                end
            end
            START: begin
                i_start  = 1'b1;
                state_nx = WAITLOW;
            end
            WAITLOW: begin
                if (!i_ready) begin
                    state_nx = RUN;
                end else if (wait_cnt == 2'd3) begin
                    state_nx = START;
                end
            end
            RUN: begin
                i_in_valid = rin_valid;
                i_in_data  = rin_data;
                rin_ack    = i_in_ack;
                rout_valid = i_out_valid;
                rout_data  = i_out_data;
                i_out_ack  = rout_ack;
                out_inc    = i_out_valid && rout_ack;
                if (i_ready && !i_out_valid) begin
                    state_nx = DONE;
                end else if (wdog_hit) begin
                    state_nx = ABORT;
                end
            end
            ABORT: begin
                if (abort_cnt) begin
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Reset kills every handshake in the same cycle so no byte is half-transferred.
        if (rst) begin
            cmd_ack    = 1'b0;
            rin_ack    = 1'b0;
            rout_valid = 1'b0;
            i_in_valid = 1'b0;
            i_out_ack  = 1'b0;
            i_start    = 1'b0;
        end
    end

    assign i_rst = rst || (state == ABORT);
    assign busy  = (state != IDLE) && (state != DONE);
    assign done  = (state == DONE);

    bf_byte_counter #(.WIDTH(8)) u_prog_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_all),
        .inc   (prog_inc),
        .count (prog_len)
    );

    bf_byte_counter #(.WIDTH(16)) u_out_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_all),
        .inc   (out_inc),
        .count (out_count)
    );

endmodule

// File: doc/bf_sequencer.md
BF_SEQUENCER -- requirements
Module: bf_sequencer

Interface
REQ-001 SHALL have parameter WDOG_CYCLES, default 1048576: RUN-state cycle limit before abort (only with BF_SEQ_WDOG_EN).
REQ-002 SHALL have parameter MAX_PROG, default 255: maximum program bytes excluding the terminator.
REQ-003 Ports (clock and reset first):
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid / cmd_ack / cmd_last / cmd_data  in / out / in / in  1/1/1/8  program byte stream from host; cmd_last marks the final byte.
- rin_valid / rin_ack / rin_data  in / out / in  1/1/8  runtime input bytes for ',' from host.
- rout_valid / rout_ack / rout_data  out / in / out  1/1/8  runtime output bytes from '.' to host.
- i_in_valid / i_in_ack / i_in_data  out / in / out  1/1/8  interpreter input channel.
- i_out_valid / i_out_ack / i_out_data  in / out / in  1/1/8  interpreter output channel.
- i_start / i_ready / i_rst  out / in / out  1/1/1  interpreter start, ready status, active-high reset request.
- busy / done / err_long / timeout  out  1 each  status flags.
- prog_len  out  8  accepted program byte count.
- out_count  out  16  bytes delivered to host.

Function
REQ-004 States SHALL be: IDLE, LOAD, TERM, START, WAITLOW, RUN, DONE, ABORT.
REQ-005 IDLE: when cmd_valid && i_ready, SHALL clear prog_len, out_count and all flags, then go to LOAD.
REQ-006 LOAD: SHALL forward cmd_* to i_in_* combinationally, with cmd_ack = i_in_ack.
REQ-007 LOAD: each handshake SHALL increment prog_len; a handshake with cmd_last SHALL go to TERM.
REQ-008 LOAD: a handshake that would make prog_len exceed MAX_PROG SHALL set err_long and go to ABORT without forwarding that byte.
REQ-009 TERM: SHALL drive i_in_valid=1, i_in_data=8'h00; on i_in_ack SHALL go to START.
REQ-010 START: SHALL assert i_start for exactly one cycle, then go to WAITLOW.
REQ-011 WAITLOW: on i_ready==0 SHALL go to RUN; if i_ready stays 1 for 4 cycles, SHALL return to START (retry).
REQ-012 RUN: SHALL connect rin_* to i_in_*.
REQ-013 RUN: SHALL connect i_out_* to rout_*; each rout handshake SHALL increment out_count (saturating at 16'hFFFF).
REQ-014 RUN: i_ready rising to 1 SHALL go to DONE; any pending output byte SHALL already have been handshaken.
REQ-015 DONE: SHALL assert done until the next cmd_valid, then behave as in IDLE (REQ-005) the same cycle.
REQ-016 ABORT: SHALL pulse i_rst for 2 cycles, hold busy=1, then go to DONE with done=1.
REQ-017 Outside the corresponding states, every *_ack and *_valid output SHALL be 0; cmd bytes are never consumed outside LOAD.
REQ-018 busy SHALL equal 1 in every state except IDLE and DONE.
REQ-019 A single cycle with both a rin handshake and an i_out handshake SHALL process both.

Reset
REQ-020 rst SHALL force IDLE; all valids, acks, i_start, busy, done, err_long and timeout to 0; prog_len and out_count to 0.
REQ-021 During rst, i_rst SHALL be 1.
REQ-022 rst mid-RUN SHALL discard in-flight bytes with no handshake completed that cycle.

Configuration
REQ-023 With BF_SEQ_WDOG_EN defined: a 21-bit counter SHALL clear on RUN entry and increment each RUN cycle.
REQ-024 With BF_SEQ_WDOG_EN defined: reaching WDOG_CYCLES SHALL set timeout and go to ABORT.
REQ-025 Without BF_SEQ_WDOG_EN: the counter SHALL be absent, timeout SHALL be tied 0, and RUN SHALL be unbounded.

Structure
REQ-026 Package bf_pkg SHALL hold the state enum and the byte constants (8'h00 EOF, '+', '-', '<', '>', '[', ']', '.', ',').
REQ-027 One sub-module, bf_byte_counter (saturating, parameterised width), SHALL be used for prog_len and out_count.

Verification
REQ-028 Load "+++." (4 bytes, last on '.'), rout_ack tied 1 -> prog_len=4; one rout byte 8'h03; done=1; out_count=1.
REQ-029 Load ",+." and send rin byte 8'h41 -> rout_data=8'h42; rin_ack high exactly once.
REQ-030 Send 256 program bytes -> err_long=1 at byte 256; i_rst pulses 2 cycles; done=1; only 255 bytes forwarded.
REQ-031 WDOG_CYCLES=100, BF_SEQ_WDOG_EN defined, program "+[]" -> timeout=1 after 100 RUN cycles, then ABORT, then done.
REQ-032 Program "..", rout_ack held 0 for 10 cycles, then 1 -> both bytes delivered in order; out_count=2; no loss.
REQ-033 Assert rst in RUN mid-output -> next cycle all outputs at reset values; state IDLE.
